// File: rtl/data_mem_responder_pkg.sv
// rtl/data_mem_responder_pkg.sv - shared types, defaults and address-check helper for the data memory responder
package data_mem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int DEF_DEPTH_WORDS = 256;
    localparam int DEF_LATENCY     = 2;

    localparam int         ADDR_LSB = 2;
    localparam logic [1:0] ALIGN_OK = 2'b00;

    // Rejects byte addresses that are not word aligned or fall past the last word.
    function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth);
        return (addr[ADDR_LSB-1:0] != ALIGN_OK) ||
               ({2'b00, addr[31:ADDR_LSB]} >= depth);
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - request/response handshake bus between initiator and responder
interface data_mem_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/mem_array_be.sv
// rtl/mem_array_be.sv - word array with byte-strobed synchronous write, combinational read, async clear
module mem_array_be #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          clr_n,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    input  logic [3:0]    wstrb,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - single-outstanding load/store responder with fixed latency and range checking
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
    parameter int LATENCY     = DEF_LATENCY
) (
    input  logic clk,
    input  logic rst,
    data_mem_responder_if.slave bus
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    state_t      state, state_nxt;
    logic [3:0]  cnt;
    logic        cap_write;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [3:0]  cap_wstrb;
    logic [31:0] rsp_rdata_q;
    logic        rsp_err_q;
    logic        err;
    logic        enter_resp;
    logic        commit;
    logic [31:0] rd;

    assign err        = addr_err(cap_addr, DEPTH_WORDS);
    assign enter_resp = (state == WAIT) && (cnt == 4'd0);
    assign commit     = enter_resp && cap_write && !err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.req_ready = rst;
                if (bus.req_valid) state_nxt = WAIT;
            end
            WAIT: begin
                if (cnt == 4'd0) state_nxt = RESP;
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Capture only on acceptance; response data is frozen on the edge entering RESP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt         <= '0;
            cap_write   <= 1'b0;
            cap_addr    <= '0;
            cap_wdata   <= '0;
            cap_wstrb   <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        cap_write <= bus.req_write;
                        cap_addr  <= bus.req_addr;
                        cap_wdata <= bus.req_wdata;
                        cap_wstrb <= bus.req_wstrb;
                        cnt       <= 4'(LATENCY - 1);
                    end
                end
                WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        rsp_err_q   <= err;
                        rsp_rdata_q <= (!cap_write && !err) ? rd : '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

    mem_array_be #(
        .DEPTH (DEPTH_WORDS),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .clr_n (rst),
        .we    (commit),
        .addr  (cap_addr[AW+1:2]),
        .wdata (cap_wdata),
        .wstrb (cap_wstrb),
        .rdata (rd)
    );

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed self-checking bench driving three responders (latency 2, 1, 15) in lockstep
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [31:0] req_addr  = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_wstrb = '0;
    logic        rsp_ready = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int lat_exp [3] = '{2, 1, 15};

    data_mem_responder_if if0 ();
    data_mem_responder_if if1 ();
    data_mem_responder_if if2 ();

    assign if0.req_valid = req_valid;  assign if1.req_valid = req_valid;  assign if2.req_valid = req_valid;
    assign if0.req_write = req_write;  assign if1.req_write = req_write;  assign if2.req_write = req_write;
    assign if0.req_addr  = req_addr;   assign if1.req_addr  = req_addr;   assign if2.req_addr  = req_addr;
    assign if0.req_wdata = req_wdata;  assign if1.req_wdata = req_wdata;  assign if2.req_wdata = req_wdata;
    assign if0.req_wstrb = req_wstrb;  assign if1.req_wstrb = req_wstrb;  assign if2.req_wstrb = req_wstrb;
    assign if0.rsp_ready = rsp_ready;  assign if1.rsp_ready = rsp_ready;  assign if2.rsp_ready = rsp_ready;

    logic [2:0]  rr, rv;
    logic [31:0] rd [3];
    logic [2:0]  re;
    assign rr    = {if2.req_ready, if1.req_ready, if0.req_ready};
    assign rv    = {if2.rsp_valid, if1.rsp_valid, if0.rsp_valid};
    assign re    = {if2.rsp_err,   if1.rsp_err,   if0.rsp_err};
    assign rd[0] = if0.rsp_rdata;
    assign rd[1] = if1.rsp_rdata;
    assign rd[2] = if2.rsp_rdata;

    data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(2))  u_dut0 (.clk(clk), .rst(rst), .bus(if0));
    data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(1))  u_dut1 (.clk(clk), .rst(rst), .bus(if1));
    data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(15)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One transaction on all three responders; hold>0 adds backpressure cycles with a competing request.
    task automatic txn(input string tag, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] st,
                       input logic [31:0] exp_rd, input logic exp_err, input int hold);
        int          lat [3];
        logic [31:0] snap;
        lat = '{0, 0, 0};
        check({tag, "_req_ready"}, 32'(rr), 32'h7);
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd; req_wstrb = st;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 3; i++) begin
                if (rv[i] && lat[i] == 0) lat[i] = k;
            end
            if (lat[0] != 0 && lat[1] != 0 && lat[2] != 0) break;
        end
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s_lat%0d", tag, i), 32'(lat[i]), 32'(lat_exp[i]));
            check($sformatf("%s_rdata%0d", tag, i), rd[i], exp_rd);
            check($sformatf("%s_err%0d", tag, i), 32'(re[i]), 32'(exp_err));
        end
        snap = rd[0];
        for (int h = 0; h < hold; h++) begin
            req_valid = 1'b1; req_write = 1'b1; req_wdata = ~wd; req_wstrb = 4'hF;
            @(posedge clk); #1;
            check($sformatf("%s_bp_valid%0d", tag, h), 32'(rv), 32'h7);
            check($sformatf("%s_bp_ready%0d", tag, h), 32'(rr), 32'h0);
            check($sformatf("%s_bp_rdata%0d", tag, h), rd[0], snap);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check({tag, "_post_ready"}, 32'(rr), 32'h7);
        check({tag, "_post_valid"}, 32'(rv), 32'h0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(rr), 32'h0);
        check("rst_rsp_valid", 32'(rv), 32'h0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("idle_req_ready", 32'(rr), 32'h7);
        check("idle_rdata", rd[0], 32'h0);
        check("idle_err", 32'(re), 32'h0);

        txn("st10", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 0);
        txn("ld10", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 0);

        txn("st20", 1'b1, 32'h20, 32'h11223344, 4'hF, 32'h0, 1'b0, 0);
        txn("st20p", 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 32'h0, 1'b0, 0);
        txn("ld20", 1'b0, 32'h20, 32'h0, 4'h0, 32'h11BB33DD, 1'b0, 0);
        txn("st20z", 1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, 32'h0, 1'b0, 0);
        txn("ld20z", 1'b0, 32'h20, 32'h0, 4'h0, 32'h11BB33DD, 1'b0, 0);

        txn("st00", 1'b1, 32'h0, 32'h01020304, 4'hF, 32'h0, 1'b0, 0);
        txn("ld22", 1'b0, 32'h22, 32'h0, 4'h0, 32'h0, 1'b1, 0);
        txn("st400", 1'b1, 32'h400, 32'hCAFEF00D, 4'hF, 32'h0, 1'b1, 0);
        txn("ld00", 1'b0, 32'h0, 32'h0, 4'h0, 32'h01020304, 1'b0, 0);
        txn("st3fc", 1'b1, 32'h3FC, 32'h87654321, 4'hF, 32'h0, 1'b0, 0);
        txn("ld3fc", 1'b0, 32'h3FC, 32'h0, 4'h0, 32'h87654321, 1'b0, 0);

        txn("bp", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 5);
        txn("ld10b", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 0);

        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h8; req_wdata = 32'h5A5A5A5A; req_wstrb = 4'hF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("midrst_valid", 32'(rv), 32'h0);
        check("midrst_ready", 32'(rr), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("postrst_ready", 32'(rr), 32'h7);
        check("postrst_valid", 32'(rv), 32'h0);
        txn("ld08", 1'b0, 32'h8, 32'h0, 4'h0, 32'h0, 1'b0, 0);
        txn("ld10c", 1'b0, 32'h10, 32'h0, 4'h0, 32'h0, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 256: number of 32-bit words in the array.
REQ-002 Parameter LATENCY, default 2, legal range 1..15: edges from request acceptance to response valid.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  1  initiator presents a request.
REQ-006 req_ready  output  1  responder can accept a request.
REQ-007 req_write  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data.
REQ-010 req_wstrb  input  4  byte enables for stores; bit i covers wdata[8i+7:8i].
REQ-011 rsp_valid  output  1  response present.
REQ-012 rsp_ready  input  1  initiator accepts the response.
REQ-013 rsp_rdata  output  32  load data; 0 for stores and errors.
REQ-014 rsp_err  output  1  access rejected (misaligned or out of range).

Function
REQ-015 The FSM SHALL have states IDLE, WAIT and RESP.
REQ-016 req_ready SHALL be 1 exactly when state is IDLE and rst is high; rsp_valid SHALL be 1 exactly in RESP.
REQ-017 In IDLE, a rising edge with req_valid=1 SHALL capture req_write, req_addr, req_wdata and req_wstrb and enter WAIT with a counter loaded to LATENCY-1.
REQ-018 In WAIT, each edge SHALL decrement the counter when it is nonzero; an edge with counter=0 SHALL enter RESP, so rsp_valid rises LATENCY edges after the acceptance edge.
REQ-019 The store commit and load sampling SHALL happen on the edge that enters RESP, using the captured fields.
REQ-020 A load SHALL return the full addressed word, and a store SHALL update only the strobed bytes; wstrb=4'b0000 SHALL be a no-op store with rsp_err=0.
REQ-021 Error SHALL be flagged when addr[1:0]!=0 or addr[31:2]>=DEPTH_WORDS; an errored access SHALL set rsp_err=1 and rsp_rdata=0, and SHALL write nothing.
REQ-022 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL hold stable until an edge with rsp_ready=1; that edge SHALL return the FSM to IDLE.
REQ-023 A new request SHALL NOT be accepted on the response-handshake edge, so req_ready rises the cycle after it.
REQ-024 Request inputs SHALL be ignored outside IDLE, and the captured fields SHALL NOT change while in WAIT or RESP.
REQ-025 Array index SHALL be addr[$clog2(DEPTH_WORDS)+1:2], after the range check has passed.
REQ-026 Transactions SHALL complete in order, one outstanding at a time; a load after a store to the same word SHALL see the stored value.

Reset
REQ-027 rst low SHALL immediately force IDLE, counter=0, rsp_valid=0, rsp_rdata=0 and rsp_err=0, and SHALL clear all captured fields.
REQ-028 rst low SHALL clear every array word to 0.
REQ-029 A transaction in WAIT or RESP when rst asserts SHALL be discarded and its store SHALL NOT commit; req_ready SHALL be 0 while rst is low.

Structure
REQ-030 A shared package SHALL hold the state enum (IDLE/WAIT/RESP), default DEPTH_WORDS and LATENCY, and the error-check constants.
REQ-031 The byte-enable storage array SHALL be one sub-module named mem_array_be, providing a synchronous write with strobes, a combinational read and an asynchronous clear.
REQ-032 The FSM, counter, capture registers and error check SHALL reside in data_mem_responder.

Verification
REQ-033 Store then load: store addr 0x10, wdata 0xDEADBEEF, wstrb 4'hF, then load 0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0; with LATENCY=2, rsp_valid rises 2 edges after each acceptance.
REQ-034 Partial store: word 0x20 holds 0x11223344; store wdata 0xAABBCCDD with wstrb 4'b0101 -> a load of 0x20 returns 0x11BB33DD.
REQ-035 Errors: load 0x22 -> rsp_err=1, rsp_rdata=0; store 0x400 with DEPTH_WORDS=256 -> rsp_err=1, and a load of 0x0 still returns its prior value.
REQ-036 Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stay stable and req_ready=0 throughout; req_ready=1 the cycle after the handshake edge.
REQ-037 Reset mid-op: accept store 0x8 = 0x5A5A5A5A, assert rst in WAIT, release -> IDLE, rsp_valid=0, and a load of 0x8 returns 0.
REQ-038 Latency sweep: LATENCY=1 and LATENCY=15 -> rsp_valid rises exactly 1 and 15 edges after acceptance.
